// File: rtl/tdc_pkg.sv
// Shared constants for the TDC fine-time path.
package tdc_pkg;

  localparam int unsigned NTAP = 63;
  localparam int unsigned OUTW = 6;

  // Tap index that cannot occur in a 63-tap ring; marks "no start edge found".
  localparam logic [OUTW-1:0] FINE_INVALID = 6'h3F;

  localparam logic [2:0] LEVEL_MIN = 3'd1;
  localparam logic [2:0] LEVEL_MAX = 3'd3;

endpackage

// File: rtl/tdc_ring_edge_detect.sv
// Ring start-edge detector: start vector, lowest start index, saturating
// edge count and popcount of the delay-line code.
module tdc_ring_edge_detect
  import tdc_pkg::*;
(
  input  logic [NTAP-1:0] code,
  output logic [NTAP-1:0] start,
  output logic [OUTW-1:0] first_idx,
  output logic [1:0]      edge_cnt,
  output logic [OUTW-1:0] pop_cnt
);

  // Predecessor of tap 0 is the last tap, so the run may wrap.
  assign start = code & ~{code[NTAP-2:0], code[NTAP-1]};

  always_comb begin
    first_idx = FINE_INVALID;
    for (int i = int'(NTAP) - 1; i >= 0; i--) begin
      if (start[i]) first_idx = OUTW'(i);
    end
  end

  always_comb begin
    edge_cnt = 2'd0;
    for (int i = 0; i < int'(NTAP); i++) begin
      if (start[i] && edge_cnt != 2'd2) edge_cnt = edge_cnt + 2'd1;
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < int'(NTAP); i++) begin
      pop_cnt = pop_cnt + OUTW'(code[i]);
    end
  end

endmodule

// File: rtl/toa_fine_encoder_core.sv
// Registered TOA fine-time encoder: run start index plus code/level error flag,
// one cycle after sampling.
module toa_fine_encoder_core
  import tdc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NTAP-1:0] encode_In,
  input  logic [2:0]      level,
  output logic [OUTW-1:0] Binary_Out,
  output logic            error
);

  logic [NTAP-1:0] start;
  logic [OUTW-1:0] first_idx;
  logic [1:0]      edge_cnt;
  logic [OUTW-1:0] pop_cnt;
  logic            level_ok;
  logic            err_d;
  logic [OUTW-1:0] bin_q;
  logic            err_q;

  tdc_ring_edge_detect u_edge (
    .code      (encode_In),
    .start     (start),
    .first_idx (first_idx),
    .edge_cnt  (edge_cnt),
    .pop_cnt   (pop_cnt)
  );

  always_comb begin
    level_ok = (level >= LEVEL_MIN) && (level <= LEVEL_MAX);
    err_d    = (edge_cnt != 2'd1) || (pop_cnt != {3'b000, level}) || !level_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      err_q <= 1'b0;
    end else begin
      bin_q <= first_idx;
      err_q <= err_d;
    end
  end

  assign Binary_Out = bin_q;
  assign error      = err_q;

endmodule

// File: tb/tb_toa_fine_encoder_core.sv
// Bench for toa_fine_encoder_core: directed table, sweeps, reset sequences and
// randomized codes against a behavioural model.
module tb_toa_fine_encoder_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [62:0] encode_In = '0;
  logic [2:0]  level = 3'd1;
  logic [5:0]  Binary_Out;
  logic        error;

  int n_vec = 0;
  int n_err = 0;

  toa_fine_encoder_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .encode_In  (encode_In),
    .level      (level),
    .Binary_Out (Binary_Out),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [62:0] code;
    logic [2:0]  lvl;
    logic [5:0]  exp_idx;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [5:0] exp_idx, input logic exp_err);
    n_vec++;
    if (Binary_Out !== exp_idx || error !== exp_err) begin
      n_err++;
      $display("FAIL %s: got idx=%0d err=%b, expected idx=%0d err=%b",
               name, Binary_Out, error, exp_idx, exp_err);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input logic [62:0] c, input logic [2:0] lv);
    @(negedge clk);
    encode_In = c;
    level     = lv;
    @(posedge clk);
    #1;
  endtask

  // Reference: scan the ring for 0->1 transitions and count ones.
  function automatic void model(input logic [62:0] c, input logic [2:0] lv,
                                output logic [5:0] idx, output logic err);
    int edges = 0;
    idx = 6'd63;
    for (int i = 0; i < 63; i++) begin
      if (c[i] && !c[(i + 62) % 63]) begin
        if (edges == 0) idx = 6'(i);
        edges++;
      end
    end
    err = (edges != 1) || ($countones(c) != int'(lv)) || (lv < 3'd1) || (lv > 3'd3);
  endfunction

  initial begin
    logic [62:0] c;
    logic [5:0]  m_idx;
    logic        m_err;
    logic [63:0] w;

    vecs[0] = '{"three_wrap",  63'h4000_0000_0000_0003, 3'd3, 6'd62, 1'b0};
    vecs[1] = '{"three_low",   63'h7,                   3'd3, 6'd0,  1'b0};
    vecs[2] = '{"two_wrap",    63'h4000_0000_0000_0001, 3'd2, 6'd62, 1'b0};
    vecs[3] = '{"bubble",      63'h4000_0000_0000_0002, 3'd3, 6'd1,  1'b1};
    vecs[4] = '{"lvl_mismatch",63'h3,                   3'd3, 6'd0,  1'b1};
    vecs[5] = '{"all_zero",    63'h0,                   3'd1, 6'd63, 1'b1};
    vecs[6] = '{"all_ones",    {63{1'b1}},              3'd3, 6'd63, 1'b1};
    vecs[7] = '{"level0",      63'h1,                   3'd0, 6'd0,  1'b1};
    vecs[8] = '{"level5",      63'h1,                   3'd5, 6'd0,  1'b1};
    vecs[9] = '{"mid_three",   63'h0000_0380_0000_0000, 3'd3, 6'd39, 1'b0};

    // Reset held across clock edges.
    encode_In = 63'h1;
    level     = 3'd1;
    #1;
    check("reset_async", 6'd0, 1'b0);
    encode_In = 63'h10;
    level     = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", 6'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].code, vecs[i].lvl);
      check(vecs[i].name, vecs[i].exp_idx, vecs[i].exp_err);
    end

    // Single-hot sweep, then wrap back to tap 0.
    c = 63'h1;
    for (int i = 0; i <= 63; i++) begin
      apply(c, 3'd1);
      check("sweep1", 6'(i % 63), 1'b0);
      c = {c[61:0], c[62]};
    end

    // Two-hot sweep; the last step is the {62,0} wrap.
    c = 63'h3;
    for (int i = 0; i < 63; i++) begin
      apply(c, 3'd2);
      check("sweep2", 6'(i), 1'b0);
      c = {c[61:0], c[62]};
    end

    // Asynchronous reset mid-stream, then recovery.
    apply(63'h20, 3'd1);
    check("pre_reset", 6'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", 6'd0, 1'b0);
    @(negedge clk);
    encode_In = 63'h0;
    level     = 3'd2;
    rst_n     = 1'b1;
    #1;
    check("released_no_edge", 6'd0, 1'b0);
    @(posedge clk);
    #1;
    check("first_after_reset", 6'd63, 1'b1);

    // Randomized codes: clean runs, runs with wrong level, and noise.
    for (int n = 0; n < 300; n++) begin
      int mode = int'($urandom_range(0, 3));
      int len  = int'($urandom_range(1, 3));
      int s    = int'($urandom_range(0, 62));
      logic [2:0] lv;
      c = '0;
      if (mode < 3) begin
        for (int k = 0; k < len; k++) c[(s + k) % 63] = 1'b1;
      end else begin
        w = {$urandom, $urandom};
        c = w[62:0] & {$urandom, $urandom};
      end
      lv = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(len);
      apply(c, lv);
      model(c, lv, m_idx, m_err);
      check("random", m_idx, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
